line_burst_adaptor: RTL and testbench

LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

---
 rtl/line_burst_adaptor_pkg.sv | 6 +
 rtl/line_burst_adaptor_timeout.sv | 24 ++
 rtl/line_burst_adaptor.sv | 104 ++++++++++
 tb/tb_line_burst_adaptor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/line_burst_adaptor_pkg.sv
// line_burst_types: shared FSM state, beat count and beat index type for the line/burst adaptor
package line_burst_types;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam int BEATS = 4;
  typedef logic [1:0] beat_t;
endpackage

// File: rtl/line_burst_adaptor_timeout.sv
// burst_timeout_counter: counts stalled burst cycles and flags expiry (exists only with BURST_TIMEOUT_EN)
`ifdef BURST_TIMEOUT_EN
module burst_timeout_counter #(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic hit_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  // restart on every beat response or whenever no burst is in flight
  always_comb begin
    cnt_d = (!en_i || hit_i) ? 8'd0 : cnt_q + 8'd1;
  end
  // stall count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = en_i && !hit_i && (cnt_q == 8'(timeout_cycles - 1));
endmodule
`endif

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: splits L2 line fills/writebacks into four bursts beats; optional abort via BURST_TIMEOUT_EN
module line_burst_adaptor
  import line_burst_types::*;
#(
  parameter int s_line         = 256,
  parameter int s_burst        = 64,
  parameter int timeout_cycles = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_address_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [s_line-1:0]  line_wdata_i,
  output logic [s_line-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [31:0]        burst_address_o,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [s_burst-1:0] burst_wdata_o,
  input  logic [s_burst-1:0] burst_rdata_i,
  input  logic               burst_resp_i
`ifdef BURST_TIMEOUT_EN
  ,
  output logic               timeout_err_o
`endif
);
  if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
    $error("timeout_cycles must fit the 8-bit stall counter");
  end
  state_t             state_q, state_d;
  beat_t              beat_q, beat_d;
  logic [31:0]        addr_q, addr_d;
  logic [s_line-1:0]  line_q, line_d;
  logic [s_line-1:0]  rdata_q, rdata_d;
  logic               expired;
  logic               active;
  assign active = (state_q == READ) || (state_q == WRITE);
`ifdef BURST_TIMEOUT_EN
  logic err_q, err_d;
  burst_timeout_counter #(.timeout_cycles(timeout_cycles)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .en_i      (active),
    .hit_i     (burst_resp_i),
    .expired_o (expired)
  );
  // the abort flag stays set until reset
  always_comb begin
    err_d = err_q || expired;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign timeout_err_o = err_q;
`else
  assign expired = 1'b0;
`endif
  // next state: accept requests in IDLE (write wins), advance beats on responses, hold during gaps
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (line_write_i || line_read_i) begin
        state_d = line_write_i ? WRITE : READ;
        addr_d  = line_address_i & ~32'h1f;
        line_d  = line_wdata_i;
        beat_d  = '0;
      end
      READ, WRITE: if (burst_resp_i) begin
        if (state_q == READ) rdata_d[s_burst*beat_q +: s_burst] = burst_rdata_i;
        beat_d  = beat_q + beat_t'(1);
        state_d = (beat_q == beat_t'(BEATS - 1)) ? DONE : state_q;
      end else if (expired) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end
  assign burst_read_o    = state_q == READ;
  assign burst_write_o   = state_q == WRITE;
  assign line_resp_o     = state_q == DONE;
  assign burst_address_o = addr_q;
  assign burst_wdata_o   = line_q[s_burst*beat_q +: s_burst];
  assign line_rdata_o    = rdata_q;
endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed and randomized checks of line_burst_adaptor against a beat-slicing model
module tb_line_burst_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i, line_write_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_address_o;
  logic         burst_read_o, burst_write_o;
  logic [63:0]  burst_wdata_o, burst_rdata_i;
  logic         burst_resp_i;
`ifdef BURST_TIMEOUT_EN
  logic         timeout_err_o;
`endif
  int checks = 0;
  int passes = 0;
  logic [255:0] last_fill = '0;

  line_burst_adaptor #(.s_line(256), .s_burst(64), .timeout_cycles(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .line_address_i  (line_address_i),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_address_o (burst_address_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
`ifdef BURST_TIMEOUT_EN
    ,
    .timeout_err_o   (timeout_err_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic run_xfer(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [255:0] wl, input logic [255:0] rl,
                          input int g0, input int g1, input int g2, input int g3);
    int gap[4];
    logic [31:0] exp_addr;
    gap = '{g0, g1, g2, g3};
    exp_addr = {a[31:5], 5'b0};
    line_address_i = a;
    line_wdata_i = wl;
    line_write_i = wr;
    line_read_i = rd;
    @(posedge clk); @(negedge clk);
    checks++; if (burst_write_o !== wr) $display("FAIL xfer_write_req: got %b expected %b", burst_write_o, wr); else passes++;
    checks++; if (burst_read_o !== !wr) $display("FAIL xfer_read_req: got %b expected %b", burst_read_o, !wr); else passes++;
    checks++; if (burst_address_o !== exp_addr) $display("FAIL xfer_addr: got %h expected %h", burst_address_o, exp_addr); else passes++;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < gap[i]; k++) begin
        checks++; if (line_resp_o !== 1'b0) $display("FAIL gap_resp beat %0d: got %b expected 0", i, line_resp_o); else passes++;
        if (wr) begin
          checks++; if (burst_wdata_o !== wl[64*i +: 64]) $display("FAIL gap_wdata beat %0d: got %h expected %h", i, burst_wdata_o, wl[64*i +: 64]); else passes++;
        end
        @(posedge clk); @(negedge clk);
      end
      if (wr) begin
        checks++; if (burst_wdata_o !== wl[64*i +: 64]) $display("FAIL beat_wdata %0d: got %h expected %h", i, burst_wdata_o, wl[64*i +: 64]); else passes++;
      end
      checks++; if (line_resp_o !== 1'b0) $display("FAIL early_resp beat %0d: got %b expected 0", i, line_resp_o); else passes++;
      burst_resp_i = 1'b1;
      burst_rdata_i = rl[64*i +: 64];
      @(posedge clk); @(negedge clk);
      burst_resp_i = 1'b0;
      burst_rdata_i = $urandom;
    end
    line_read_i = 1'b0;
    line_write_i = 1'b0;
    if (!wr) last_fill = rl;
    checks++; if (line_resp_o !== 1'b1) $display("FAIL done_resp: got %b expected 1", line_resp_o); else passes++;
    checks++; if ({burst_read_o, burst_write_o} !== 2'b00) $display("FAIL done_drop: got %b expected 00", {burst_read_o, burst_write_o}); else passes++;
    checks++; if (line_rdata_o !== last_fill) $display("FAIL rdata: got %h expected %h", line_rdata_o, last_fill); else passes++;
    @(posedge clk); @(negedge clk);
    checks++; if (line_resp_o !== 1'b0) $display("FAIL resp_one_cycle: got %b expected 0", line_resp_o); else passes++;
    checks++; if ({burst_read_o, burst_write_o} !== 2'b00) $display("FAIL back_idle: got %b expected 00", {burst_read_o, burst_write_o}); else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_address_i = '0; line_read_i = 0; line_write_i = 0; line_wdata_i = '0;
    burst_rdata_i = '0; burst_resp_i = 0;
    repeat (2) @(negedge clk);
    checks++; if ({burst_read_o, burst_write_o, line_resp_o} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {burst_read_o, burst_write_o, line_resp_o}); else passes++;
    checks++; if (burst_address_o !== 32'h0) $display("FAIL reset_addr: got %h expected 0", burst_address_o); else passes++;
    checks++; if (line_rdata_o !== 256'h0) $display("FAIL reset_rdata: got %h expected 0", line_rdata_o); else passes++;
    checks++; if (burst_wdata_o !== 64'h0) $display("FAIL reset_wdata: got %h expected 0", burst_wdata_o); else passes++;
`ifdef BURST_TIMEOUT_EN
    checks++; if (timeout_err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", timeout_err_o); else passes++;
`endif
    rst = 1'b0;
    last_fill = '0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    run_xfer(0, 1, 32'h0000_1234, '0,
             {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 0, 0, 0, 0);
  endtask

  task automatic test_writeback();
    run_xfer(1, 0, 32'h0000_8000,
             {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}}, rand_line(), 0, 2, 0, 3);
  endtask

  task automatic test_both_requests();
    run_xfer(1, 1, 32'hCAFE_0040, rand_line(), rand_line(), 1, 0, 1, 0);
  endtask

  task automatic test_stray_resp();
    line_read_i = 0; line_write_i = 0;
    burst_resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      burst_rdata_i = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      checks++; if ({burst_read_o, burst_write_o, line_resp_o} !== 3'b000) $display("FAIL stray_ctrl: got %b expected 000", {burst_read_o, burst_write_o, line_resp_o}); else passes++;
      checks++; if (line_rdata_o !== last_fill) $display("FAIL stray_rdata: got %h expected %h", line_rdata_o, last_fill); else passes++;
    end
    burst_resp_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] l;
    l = rand_line();
    line_address_i = 32'h0000_0100; line_read_i = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      burst_resp_i = 1'b1; burst_rdata_i = l[64*i +: 64];
      @(posedge clk); @(negedge clk);
    end
    burst_resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (burst_read_o !== 1'b0) $display("FAIL async_drop: got %b expected 0", burst_read_o); else passes++;
    checks++; if (line_rdata_o !== 256'h0) $display("FAIL async_rdata_clear: got %h expected 0", line_rdata_o); else passes++;
    checks++; if (burst_address_o !== 32'h0) $display("FAIL async_addr_clear: got %h expected 0", burst_address_o); else passes++;
    line_read_i = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (line_resp_o !== 1'b0) $display("FAIL abandoned_resp: got %b expected 0", line_resp_o); else passes++;
    rst = 1'b0;
    last_fill = '0;
    @(negedge clk);
    run_xfer(0, 1, 32'h0000_0100, rand_line(), rand_line(), 0, 1, 0, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      run_xfer(wr, !wr || 1'($urandom_range(0, 1)), $urandom, rand_line(), rand_line(),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

`ifdef BURST_TIMEOUT_EN
  task automatic test_timeout();
    line_address_i = 32'h0000_2000; line_read_i = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++; if (line_resp_o !== 1'b0) $display("FAIL timeout_early stall %0d: got %b expected 0", k + 1, line_resp_o); else passes++;
      @(posedge clk); @(negedge clk);
    end
    line_read_i = 1'b0;
    checks++; if (line_resp_o !== 1'b1) $display("FAIL timeout_resp: got %b expected 1", line_resp_o); else passes++;
    checks++; if (timeout_err_o !== 1'b1) $display("FAIL timeout_err: got %b expected 1", timeout_err_o); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (timeout_err_o !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", timeout_err_o); else passes++;
    checks++; if (line_resp_o !== 1'b0) $display("FAIL timeout_resp_once: got %b expected 0", line_resp_o); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (timeout_err_o !== 1'b0) $display("FAIL timeout_err_clear: got %b expected 0", timeout_err_o); else passes++;
    @(negedge clk);
    rst = 1'b0;
    last_fill = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_stray_resp();
    test_fill();
    test_writeback();
    test_both_requests();
    test_stray_resp();
    test_reset_mid_burst();
    test_random();
`ifdef BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
